// File: rtl/beam_pkg.sv
// Shared constants and FSM state type for the beam scan controller.
package beam_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int N_ANGLES    = 181;
  localparam int ANG_W       = $clog2(N_ANGLES);
  localparam int PWR_W       = 2 * (2 * WORD_LENGTH + 3) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/peak_tracker.sv
// Running maximum of datapath power over one scan; the earliest angle wins a tie.
module peak_tracker #(
  parameter int ANG_W = beam_pkg::ANG_W,
  parameter int PWR_W = beam_pkg::PWR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cmp_v,
  input  logic [ANG_W-1:0] cmp_idx,
  input  logic [PWR_W-1:0] dp_power,
  output logic [PWR_W-1:0] peak_power,
  output logic [ANG_W-1:0] peak_idx
);

  logic seen;

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen       <= 1'b0;
      peak_power <= '0;
      peak_idx   <= '0;
    end else if (clear) begin
      seen <= 1'b0;
    end else if (cmp_v && (!seen || dp_power > peak_power)) begin
      seen       <= 1'b1;
      peak_power <= dp_power;
      peak_idx   <= cmp_idx;
    end
  end

endmodule

// File: rtl/beam_scan_ctrl.sv
// Snapshot-in / peak-out sequencer that walks the steering ROM for the power datapath.
// Define BEAM_SCAN_STREAM_EN to build the per-angle power stream on pwr_valid/pwr_idx/pwr_data.
module beam_scan_ctrl #(
  parameter int WORD_LENGTH = beam_pkg::WORD_LENGTH,
  parameter int N_ANGLES    = beam_pkg::N_ANGLES,
  parameter int ANG_W       = $clog2(N_ANGLES),
  parameter int PWR_W       = 2 * (2 * WORD_LENGTH + 3) + 1,
  parameter int CFG_W       = $clog2(N_ANGLES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WORD_LENGTH-1:0] I_x1,
  input  logic signed [WORD_LENGTH-1:0] I_x2,
  input  logic signed [WORD_LENGTH-1:0] I_x3,
  input  logic signed [WORD_LENGTH-1:0] I_x4,
  input  logic signed [WORD_LENGTH-1:0] Q_x1,
  input  logic signed [WORD_LENGTH-1:0] Q_x2,
  input  logic signed [WORD_LENGTH-1:0] Q_x3,
  input  logic signed [WORD_LENGTH-1:0] Q_x4,
  input  logic        [CFG_W-1:0]       cfg_num_angles,
  input  logic                          abort,
  output logic signed [WORD_LENGTH-1:0] snap_I1,
  output logic signed [WORD_LENGTH-1:0] snap_I2,
  output logic signed [WORD_LENGTH-1:0] snap_I3,
  output logic signed [WORD_LENGTH-1:0] snap_I4,
  output logic signed [WORD_LENGTH-1:0] snap_Q1,
  output logic signed [WORD_LENGTH-1:0] snap_Q2,
  output logic signed [WORD_LENGTH-1:0] snap_Q3,
  output logic signed [WORD_LENGTH-1:0] snap_Q4,
  output logic        [ANG_W-1:0]       steer_addr,
  output logic                          steer_en,
  input  logic        [PWR_W-1:0]       dp_power,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic        [PWR_W-1:0]       peak_power,
  output logic        [ANG_W-1:0]       peak_idx,
  output logic                          busy,
  output logic                          pwr_valid,
  output logic        [ANG_W-1:0]       pwr_idx,
  output logic        [PWR_W-1:0]       pwr_data
);

  import beam_pkg::*;

  state_t           state, state_nx;
  logic [ANG_W-1:0] addr, last_addr, cmp_idx;
  logic             cmp_v, take, abort_act, last_hit;
  logic [CFG_W-1:0] num_sel;

  assign take      = in_valid && (state == IDLE);
  assign abort_act = abort && (state != IDLE);
  assign last_hit  = (addr == last_addr);
  // Zero or out-of-range counts fall back to a full sweep.
  assign num_sel   = (cfg_num_angles == '0 || cfg_num_angles > CFG_W'(N_ANGLES))
                     ? CFG_W'(N_ANGLES) : cfg_num_angles;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = SCAN;
      SCAN:    if (abort) state_nx = IDLE; else if (last_hit) state_nx = DRAIN;
      DRAIN:   state_nx = abort ? IDLE : DONE;
      DONE:    if (abort || result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {snap_I1, snap_I2, snap_I3, snap_I4} <= '0;
      {snap_Q1, snap_Q2, snap_Q3, snap_Q4} <= '0;
      addr      <= '0;
      last_addr <= '0;
      cmp_v     <= 1'b0;
      cmp_idx   <= '0;
    end else begin
      if (take) begin
        {snap_I1, snap_I2, snap_I3, snap_I4} <= {I_x1, I_x2, I_x3, I_x4};
        {snap_Q1, snap_Q2, snap_Q3, snap_Q4} <= {Q_x1, Q_x2, Q_x3, Q_x4};
        last_addr <= ANG_W'(num_sel - 1'b1);
        addr      <= '0;
      end else if (state == SCAN && !last_hit) begin
        addr <= addr + 1'b1;
      end
      // ROM data lags the address by one cycle; this pair names the angle dp_power reflects.
      cmp_v   <= (state == SCAN) && !abort;
      cmp_idx <= addr;
    end
  end

  peak_tracker #(.ANG_W(ANG_W), .PWR_W(PWR_W)) u_peak (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (take || abort_act),
    .cmp_v      (cmp_v && !abort_act),
    .cmp_idx    (cmp_idx),
    .dp_power   (dp_power),
    .peak_power (peak_power),
    .peak_idx   (peak_idx)
  );

  assign in_ready     = rst_n && (state == IDLE);
  assign steer_en     = (state == SCAN);
  assign steer_addr   = addr;
  assign result_valid = (state == DONE);
  assign busy         = (state == SCAN) || (state == DONE);

`ifdef BEAM_SCAN_STREAM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwr_valid <= 1'b0;
      pwr_idx   <= '0;
      pwr_data  <= '0;
    end else begin
      pwr_valid <= cmp_v && !abort_act;
      pwr_idx   <= cmp_idx;
      pwr_data  <= dp_power;
    end
  end
`else
  assign pwr_valid = 1'b0;
  assign pwr_idx   = '0;
  assign pwr_data  = '0;
`endif

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Randomized bench for beam_scan_ctrl against a cycle-count model of the scan, N_ANGLES=8.
`timescale 1ns/1ps
module tb_beam_scan_ctrl;
  import beam_pkg::*;

  localparam int WL = WORD_LENGTH;
  localparam int NA = 8;
  localparam int AW = $clog2(NA);
  localparam int PW = 2 * (2 * WL + 3) + 1;
  localparam int CW = $clog2(NA + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, result_ready = 1'b0;
  logic signed [WL-1:0] ix [4];
  logic signed [WL-1:0] qx [4];
  logic [CW-1:0] cfg = '0;
  logic in_ready, steer_en, result_valid, busy, pwr_valid;
  logic signed [WL-1:0] si [4];
  logic signed [WL-1:0] sq [4];
  logic [AW-1:0] steer_addr, peak_idx, pwr_idx;
  logic [PW-1:0] dp_power, peak_power, pwr_data;
  logic [PW-1:0] rom_pw [NA];
  logic [PW-1:0] rom_q = '0;
  int dir_pw [NA] = '{3, 9, 1, 40, 7, 40, 2, 0};

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Steering ROM plus datapath stand-in: power for the addressed angle one cycle after the read.
  always @(posedge clk) if (steer_en) rom_q <= rom_pw[steer_addr];
  assign dp_power = rom_q;

  beam_scan_ctrl #(.N_ANGLES(NA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .I_x1(ix[0]), .I_x2(ix[1]), .I_x3(ix[2]), .I_x4(ix[3]),
    .Q_x1(qx[0]), .Q_x2(qx[1]), .Q_x3(qx[2]), .Q_x4(qx[3]),
    .cfg_num_angles(cfg), .abort(abort),
    .snap_I1(si[0]), .snap_I2(si[1]), .snap_I3(si[2]), .snap_I4(si[3]),
    .snap_Q1(sq[0]), .snap_Q2(sq[1]), .snap_Q3(sq[2]), .snap_Q4(sq[3]),
    .steer_addr(steer_addr), .steer_en(steer_en), .dp_power(dp_power),
    .result_valid(result_valid), .result_ready(result_ready),
    .peak_power(peak_power), .peak_idx(peak_idx), .busy(busy),
    .pwr_valid(pwr_valid), .pwr_idx(pwr_idx), .pwr_data(pwr_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a scan is "busy" from the handshake until abort, reset or result accepted;
  // m_t counts cycles since the handshake edge (cycle 1 is the first after it).
  bit m_valid = 0, m_busy = 0, m_zero = 0;
  int m_t = 0, m_num = 0;
  logic [PW-1:0] m_pw [NA];
  logic signed [WL-1:0] m_si [4];
  logic signed [WL-1:0] m_sq [4];

  function automatic void exp_peak(output logic [PW-1:0] p, output int idx);
    p = m_pw[0];
    idx = 0;
    for (int k = 1; k < m_num; k++)
      if (m_pw[k] > p) begin p = m_pw[k]; idx = k; end
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin m_si[i] = '0; m_sq[i] = '0; end
    for (int k = 0; k < NA; k++) m_pw[k] = '0;
    forever begin
      @(posedge clk);
      m_valid = 1;
      m_zero  = 0;
      if (!rst_n) begin
        m_busy = 0;
        m_zero = 1;
        for (int i = 0; i < 4; i++) begin m_si[i] = '0; m_sq[i] = '0; end
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1;
          m_t    = 1;
          m_num  = (cfg == 0 || int'(cfg) > NA) ? NA : int'(cfg);
          for (int i = 0; i < 4; i++) begin m_si[i] = ix[i]; m_sq[i] = qx[i]; end
          for (int k = 0; k < NA; k++) m_pw[k] = rom_pw[k];
        end
      end else if (abort) begin
        m_busy = 0;
      end else if (m_t >= m_num + 2 && result_ready) begin
        m_busy = 0;
      end else begin
        m_t++;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  initial begin
    logic [PW-1:0] ep;
    int ei;
    bit e_steer, e_rv, e_busy, e_pv;
    forever begin
      @(negedge clk);
      if (!m_valid) continue;
      if (!rst_n) begin
        check("in_ready_in_reset", in_ready, 1'b0);
        continue;
      end
      if (m_zero) begin
        check("rst_steer_addr", steer_addr, '0);
        check("rst_peak_power", peak_power, '0);
        check("rst_peak_idx", peak_idx, '0);
        check("rst_pwr_valid", pwr_valid, 1'b0);
        check("rst_pwr_data", pwr_data, '0);
      end
      e_steer = m_busy && m_t <= m_num;
      e_rv    = m_busy && m_t >= m_num + 2;
      e_busy  = m_busy && (m_t <= m_num || m_t >= m_num + 2);
      e_pv    = m_busy && m_t >= 3 && m_t <= m_num + 2;
      check("in_ready", in_ready, !m_busy);
      check("steer_en", steer_en, e_steer);
      if (e_steer) check("steer_addr", steer_addr, m_t - 1);
      check("result_valid", result_valid, e_rv);
      check("busy", busy, e_busy);
      if (e_rv) begin
        exp_peak(ep, ei);
        check("peak_power", peak_power, ep);
        check("peak_idx", peak_idx, ei);
      end
      for (int i = 0; i < 4; i++) begin
        check("snap_I", si[i], m_si[i]);
        check("snap_Q", sq[i], m_sq[i]);
      end
`ifdef BEAM_SCAN_STREAM_EN
      check("pwr_valid", pwr_valid, e_pv);
      if (e_pv) begin
        check("pwr_idx", pwr_idx, m_t - 3);
        check("pwr_data", pwr_data, m_pw[m_t-3]);
      end
`else
      check("pwr_valid_off", pwr_valid, 1'b0);
      check("pwr_idx_off", pwr_idx, '0);
      check("pwr_data_off", pwr_data, '0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_snap();
    for (int i = 0; i < 4; i++) begin
      ix[i] = WL'($urandom);
      qx[i] = WL'($urandom);
    end
  endtask

  task automatic start_scan(input int cfg_v);
    int w = 0;
    while (m_busy && w < 50) begin step(); w++; end
    if (m_busy) check("idle_wait", m_busy, 1'b0);
    rand_snap();
    cfg = CW'(cfg_v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cfg = CW'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 ready 5 cycles after result_valid, 2 random.
  task automatic run_scan(input int ready_mode, input int abort_at, input int reset_at,
                          output int first_rv, output int end_n,
                          output logic [PW-1:0] cap_pp, output int cap_pi, output int n_pulse);
    int n = 1;
    first_rv = 0; n_pulse = 0; cap_pp = '0; cap_pi = 0;
    while (m_busy && n < 200) begin
      abort = (n == abort_at);
      rst_n = (n != reset_at);
      case (ready_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = (first_rv != 0 && n >= first_rv + 5);
        default: result_ready = 1'($urandom_range(0, 1));
      endcase
      rand_snap();
      @(negedge clk);
      if (pwr_valid) n_pulse++;
      if (result_valid && first_rv == 0) begin
        first_rv = n;
        cap_pp = peak_power;
        cap_pi = int'(peak_idx);
      end
      step();
      n++;
    end
    abort = 1'b0;
    rst_n = 1'b1;
    result_ready = 1'b0;
    end_n = n;
    if (n >= 200) check("scan_timeout", n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, en, pi, np, num, ab;
    logic [PW-1:0] pp;
    for (int i = 0; i < 4; i++) begin ix[i] = '0; qx[i] = '0; end
    for (int k = 0; k < NA; k++) rom_pw[k] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_result_valid", result_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_snap_I1", si[0], '0);
    step();

    // abort while idle must be ignored
    abort = 1'b1;
    step();
    step();
    abort = 1'b0;

    // directed powers with a tie at the peak, ready held off 5 cycles
    for (int k = 0; k < NA; k++) rom_pw[k] = PW'(dir_pw[k]);
    start_scan(8);
    run_scan(1, 0, 0, fr, en, pp, pi, np);
    check("dir_rv_cycle", fr, 10);
    check("dir_peak_power", pp, 40);
    check("dir_peak_idx", pi, 3);
    check("dir_accept_cycle", en, 16);
`ifdef BEAM_SCAN_STREAM_EN
    check("dir_pulse_count", np, 8);
`else
    check("dir_pulse_count_off", np, 0);
`endif
    @(negedge clk);
    check("dir_in_ready_after", in_ready, 1'b1);

    start_scan(8);
    run_scan(0, 0, 0, fr, en, pp, pi, np);
    check("tput_rv_cycle", fr, 10);
    check("tput_in_ready_cycle", en, 11);

    start_scan(8);
    run_scan(0, 4, 0, fr, en, pp, pi, np);
    check("abort_no_result", fr, 0);
    check("abort_idle_cycle", en, 5);
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);

    start_scan(0);
    run_scan(0, 0, 0, fr, en, pp, pi, np);
    check("cfg0_rv_cycle", fr, 10);
    start_scan(9);
    run_scan(0, 0, 0, fr, en, pp, pi, np);
    check("cfg9_rv_cycle", fr, 10);
    start_scan(1);
    run_scan(0, 0, 0, fr, en, pp, pi, np);
    check("cfg1_rv_cycle", fr, 3);
    check("cfg1_peak_power", pp, 3);
    check("cfg1_peak_idx", pi, 0);

    start_scan(8);
    run_scan(0, 0, 4, fr, en, pp, pi, np);
    check("rst_mid_idle_cycle", en, 5);
    @(negedge clk);
    check("rst_mid_steer_en", steer_en, 1'b0);
    check("rst_mid_peak_power", peak_power, '0);
    check("rst_mid_in_ready", in_ready, 1'b1);

    // randomized scans: small power range to provoke ties
    repeat (60) begin
      for (int k = 0; k < NA; k++) rom_pw[k] = PW'($urandom_range(0, 31));
      num = $urandom_range(0, 15);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      start_scan(num);
      run_scan($urandom_range(0, 2), ab, 0, fr, en, pp, pi, np);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
